// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Priority: mem wait > mispredict > load-use > send-full > interrupt.
// Controls are combinational from registered state and current inputs. State, counters and flags update on posedge clk.
module pipe_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int MEM_TO = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_p0_addr,
    input  logic [3:0]       id_p1_addr,
    input  logic             id_use_p0,
    input  logic             id_use_p1,
    input  logic             ex_mem_re,
    input  logic [3:0]       ex_dst_addr,
    input  logic             ex_send,
    input  logic             spart_full,
    input  logic             mispredict,
    input  logic             mem_busy,
    input  logic             accel_busy,
    input  logic             int_req,
    output logic             pc_hold,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             stall_id_ex,
    output logic             flush_id_ex,
    output logic             store_current,
    output logic             stall_ex_mem,
    output logic             accelerator_stall,
    output logic             int_ack,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_INTSAVE = 2'd2
    } state_t;

    localparam int            BW       = 10;
    localparam logic [BW-1:0] MEM_TO_V = BW'(MEM_TO);

    state_t            r_state;
    logic              r_int_pend;
    logic [BW-1:0]     r_busy_cnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_cycles;

    logic              w_loaduse;
    logic              w_sendfull;
    logic              w_pc_hold;
    logic              w_stall_if_id;
    logic              w_flush_if_id;
    logic              w_stall_id_ex;
    logic              w_flush_id_ex;
    logic              w_store_current;
    logic              w_stall_ex_mem;
    logic              w_accel_stall;
    logic              w_int_ack;
    logic [BW-1:0]     w_busy_nxt;
    state_t            w_next_state;

    // Register 0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign w_loaduse  = ex_mem_re && (ex_dst_addr != 4'd0) &&
                        ((id_use_p0 && (id_p0_addr == ex_dst_addr)) ||
                         (id_use_p1 && (id_p1_addr == ex_dst_addr)));
    assign w_sendfull = ex_send && spart_full;

    // MEMWAIT with mem_busy low behaves exactly like RUN, so only INTSAVE needs its own branch.
    always_comb begin
        w_pc_hold       = 1'b0;
        w_stall_if_id   = 1'b0;
        w_flush_if_id   = 1'b0;
        w_stall_id_ex   = 1'b0;
        w_flush_id_ex   = 1'b0;
        w_store_current = 1'b0;
        w_stall_ex_mem  = 1'b0;
        w_accel_stall   = 1'b0;
        w_int_ack       = 1'b0;
        w_next_state    = ST_RUN;
        if (mem_busy) begin
            w_pc_hold      = 1'b1;
            w_stall_if_id  = 1'b1;
            w_stall_id_ex  = 1'b1;
            w_stall_ex_mem = 1'b1;
            w_accel_stall  = accel_busy;
            w_next_state   = ST_MEMWAIT;
        end else if (r_state == ST_INTSAVE) begin
            w_store_current = 1'b1;
            w_flush_if_id   = 1'b1;
            w_int_ack       = 1'b1;
        end else if (mispredict) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (w_loaduse) begin
            w_pc_hold     = 1'b1;
            w_stall_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (w_sendfull) begin
            w_pc_hold     = 1'b1;
            w_stall_if_id = 1'b1;
            w_stall_id_ex = 1'b1;
        end else if (r_int_pend) begin
            w_next_state = ST_INTSAVE;
        end
    end

    assign w_busy_nxt = !mem_busy                 ? '0 :
                        (r_busy_cnt == MEM_TO_V)  ? r_busy_cnt :
                                                    r_busy_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_int_pend     <= 1'b0;
            r_busy_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_next_state;
            // A request arriving during the accepted save cycle is absorbed by that entry.
            r_int_pend <= w_int_ack ? 1'b0 : (r_int_pend | int_req);
            r_busy_cnt <= w_busy_nxt;
            if (mem_busy && (w_busy_nxt == MEM_TO_V))
                r_mem_timeout <= 1'b1;
            if (w_pc_hold && !(&r_stall_cycles))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    // Combinational controls are forced low while reset is held.
    assign pc_hold           = w_pc_hold       & ~rst;
    assign stall_if_id       = w_stall_if_id   & ~rst;
    assign flush_if_id       = w_flush_if_id   & ~rst;
    assign stall_id_ex       = w_stall_id_ex   & ~rst;
    assign flush_id_ex       = w_flush_id_ex   & ~rst;
    assign store_current     = w_store_current & ~rst;
    assign stall_ex_mem      = w_stall_ex_mem  & ~rst;
    assign accelerator_stall = w_accel_stall   & ~rst;
    assign int_ack           = w_int_ack       & ~rst;
    assign mem_timeout       = r_mem_timeout;
    assign stall_cycles      = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded random/directed bench for pipe_hazard_ctrl against a cycle-level priority model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W  = 8;
    localparam int MEM_TO = 8;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       id_p0_addr = '0;
    logic [3:0]       id_p1_addr = '0;
    logic             id_use_p0 = 1'b0;
    logic             id_use_p1 = 1'b0;
    logic             ex_mem_re = 1'b0;
    logic [3:0]       ex_dst_addr = '0;
    logic             ex_send = 1'b0;
    logic             spart_full = 1'b0;
    logic             mispredict = 1'b0;
    logic             mem_busy = 1'b0;
    logic             accel_busy = 1'b0;
    logic             int_req = 1'b0;
    logic             pc_hold, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
    logic             store_current, stall_ex_mem, accelerator_stall, int_ack, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TO(MEM_TO)) dut (
        .clk(clk), .rst(rst),
        .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
        .id_use_p0(id_use_p0), .id_use_p1(id_use_p1),
        .ex_mem_re(ex_mem_re), .ex_dst_addr(ex_dst_addr),
        .ex_send(ex_send), .spart_full(spart_full),
        .mispredict(mispredict), .mem_busy(mem_busy), .accel_busy(accel_busy),
        .int_req(int_req),
        .pc_hold(pc_hold), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .stall_id_ex(stall_id_ex), .flush_id_ex(flush_id_ex),
        .store_current(store_current), .stall_ex_mem(stall_ex_mem),
        .accelerator_stall(accelerator_stall), .int_ack(int_ack),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] p0, p1;
        logic       u0, u1, re;
        logic [3:0] dst;
        logic       send, full, mp, mb, ab, ir;
    } in_t;

    typedef struct packed {
        logic             pc_hold, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;
        logic             store_current, stall_ex_mem, accel_stall, int_ack, mem_timeout;
        logic [CNT_W-1:0] stall_cycles;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;
    string phase    = "init";

    // Reference model: interrupt pending flag, a "save due next cycle" flag,
    // consecutive busy length, timeout flag and an unbounded stall count.
    bit m_pend, m_save, m_to;
    int m_busy, m_stalls;

    function automatic exp_t model_step(input in_t v);
        exp_t e;
        bit   lu, sf, taken, go;
        e = '0;
        taken = 1'b0;
        go = 1'b0;
        if (v.rst) begin
            m_pend = 0; m_save = 0; m_to = 0; m_busy = 0; m_stalls = 0;
            return e;
        end
        e.mem_timeout  = m_to;
        e.stall_cycles = (m_stalls > SAT) ? CNT_W'(SAT) : CNT_W'(m_stalls);
        lu = v.re && (v.dst != 0) && ((v.u0 && v.p0 == v.dst) || (v.u1 && v.p1 == v.dst));
        sf = v.send && v.full;
        if (v.mb) begin
            e.pc_hold = 1; e.stall_if_id = 1; e.stall_id_ex = 1; e.stall_ex_mem = 1;
            e.accel_stall = v.ab;
        end else if (m_save) begin
            e.store_current = 1; e.flush_if_id = 1; e.int_ack = 1; taken = 1;
        end else if (v.mp) begin
            e.flush_if_id = 1; e.flush_id_ex = 1;
        end else if (lu) begin
            e.pc_hold = 1; e.stall_if_id = 1; e.flush_id_ex = 1;
        end else if (sf) begin
            e.pc_hold = 1; e.stall_if_id = 1; e.stall_id_ex = 1;
        end else if (m_pend) begin
            go = 1;
        end
        m_stalls += int'(e.pc_hold);
        m_busy = v.mb ? ((m_busy < MEM_TO) ? m_busy + 1 : MEM_TO) : 0;
        if (v.mb && m_busy >= MEM_TO) m_to = 1;
        m_pend = !taken && (m_pend || v.ir);
        m_save = go;
        return e;
    endfunction

    task automatic cyc(input in_t v);
        @(posedge clk);
        #1;
        rst = v.rst; id_p0_addr = v.p0; id_p1_addr = v.p1;
        id_use_p0 = v.u0; id_use_p1 = v.u1; ex_mem_re = v.re; ex_dst_addr = v.dst;
        ex_send = v.send; spart_full = v.full; mispredict = v.mp;
        mem_busy = v.mb; accel_busy = v.ab; int_req = v.ir;
        sb.push_back(model_step(v));
    endtask

    function automatic in_t rnd();
        in_t v;
        v      = '0;
        v.p0   = 4'($urandom_range(0, 3));
        v.p1   = 4'($urandom_range(0, 3));
        v.dst  = 4'($urandom_range(0, 3));
        v.u0   = 1'($urandom_range(0, 1));
        v.u1   = 1'($urandom_range(0, 1));
        v.re   = ($urandom_range(0, 2) == 0);
        v.send = ($urandom_range(0, 3) == 0);
        v.full = 1'($urandom_range(0, 1));
        v.mp   = ($urandom_range(0, 9) == 0);
        v.mb   = ($urandom_range(0, 7) == 0);
        v.ab   = 1'($urandom_range(0, 1));
        v.ir   = ($urandom_range(0, 9) == 0);
        v.rst  = ($urandom_range(0, 299) == 0);
        return v;
    endfunction

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {pc_hold, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex,
                       store_current, stall_ex_mem, accelerator_stall, int_ack,
                       mem_timeout, stall_cycles};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s t=%0t flags got=%b exp=%b stall_cycles got=%0d exp=%0d (flags: pc_hold stall_if_id flush_if_id stall_id_ex flush_id_ex store_current stall_ex_mem accel_stall int_ack mem_timeout)",
                             phase, $time, got[CNT_W+9:CNT_W], e[CNT_W+9:CNT_W],
                             got.stall_cycles, e.stall_cycles);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v, z, rs;
        int  burst;
        z = '0;
        rs = '0; rs.rst = 1'b1;

        phase = "reset";
        repeat (3) cyc(rs);
        cyc(z);

        phase = "loaduse";
        v = '0; v.re = 1; v.dst = 4'd3; v.u1 = 1; v.p1 = 4'd3;
        cyc(v); cyc(z); cyc(z);
        phase = "loaduse_r0";
        v.dst = 4'd0; v.p1 = 4'd0;
        cyc(v); cyc(z);

        phase = "memwait";
        v = '0; v.mb = 1; v.ab = 1;
        repeat (4) cyc(v);
        cyc(z); cyc(z);

        phase = "mispredict";
        v = '0; v.re = 1; v.dst = 4'd5; v.u0 = 1; v.p0 = 4'd5; v.mp = 1;
        cyc(v); cyc(z);
        v.mb = 1;
        cyc(v); cyc(z);

        phase = "int_sendfull";
        v = '0; v.send = 1; v.full = 1; v.ir = 1;
        cyc(v);
        v.ir = 0;
        cyc(v); cyc(v);
        repeat (4) cyc(z);

        phase = "int_vs_mem";
        v = '0; v.ir = 1;
        cyc(v); cyc(z);
        v = '0; v.mb = 1;
        cyc(v); cyc(v);
        repeat (3) cyc(z);

        phase = "timeout";
        cyc(rs);
        v = '0; v.mb = 1;
        repeat (20) cyc(v);
        repeat (3) cyc(z);
        cyc(rs);
        cyc(z);

        phase = "reset_midstall";
        v = '0; v.mb = 1; v.send = 1; v.full = 1;
        cyc(v); cyc(v);
        v.rst = 1;
        cyc(v);
        cyc(z);

        phase = "saturate";
        cyc(rs);
        v = '0; v.re = 1; v.dst = 4'd7; v.u0 = 1; v.p0 = 4'd7;
        repeat ((1 << CNT_W) + 5) begin
            cyc(v);
            cyc(z);
        end

        phase = "random";
        cyc(rs);
        burst = 0;
        repeat (3000) begin
            v = rnd();
            if (burst == 0 && $urandom_range(0, 60) == 0) burst = $urandom_range(2, 14);
            if (burst > 0) begin
                v.mb = 1'b1;
                v.rst = 1'b0;
                burst--;
            end
            cyc(v);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
